// File: rtl/pipo_reg.sv
// pipo_reg: 4-bit parallel-in/parallel-out storage register.
// Each output bit is a D flip-flop fed only by the matching input bit.
// The block loads every cycle while out of reset. A low rst clears it on the
// next rising clk edge, and rst has no effect between edges.
module pipo_reg (
  input  logic clk,
  input  logic rst,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  output logic q0,
  output logic q1,
  output logic q2,
  output logic q3
);

  // Gather the scalar inputs so the storage below is written as one nibble.
  // Bit N is still fed only by dN. No bit feeds another bit.
  logic [3:0] d_bus;
  logic [3:0] q_bus;

  assign d_bus = {d3, d2, d1, d0};

  // Synchronous clear has priority over data. Otherwise all four bits load together.
  always_ff @(posedge clk) begin
    // NOTE: use non-blocking (<=) assignments for flop state, so every bit samples its pre-edge input.
    if (!rst) begin
      q_bus <= 4'b0000;
    end else begin
      q_bus <= d_bus;
    end
  end

  // The outputs come straight from the flops, with no logic after them.
  assign q0 = q_bus[0];
  assign q1 = q_bus[1];
  assign q2 = q_bus[2];
  assign q3 = q_bus[3];

endmodule

// File: tb/tb_pipo_reg.sv
// tb_pipo_reg: self-checking bench for pipo_reg.
// Expected nibbles are pushed to a queue when stimulus is driven, then popped
// and compared 1 ns after the rising edge that should produce them.
module tb_pipo_reg;

  logic clk;
  logic rst;
  logic [3:0] dv;
  logic q0, q1, q2, q3;
  logic [3:0] qv;

  logic [3:0] sb[$];
  logic [3:0] exp_q;
  int passed;
  int total;

  assign qv = {q3, q2, q1, q0};

  pipo_reg dut (
    .clk(clk),
    .rst(rst),
    .d0 (dv[0]),
    .d1 (dv[1]),
    .d2 (dv[2]),
    .d3 (dv[3]),
    .q0 (q0),
    .q1 (q1),
    .q2 (q2),
    .q3 (q3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reset with every data bit at 1. The output must be zero after 4 edges in a row.
  task automatic test_reset();
    rst = 1'b0;
    dv  = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(4'b0000);
      @(posedge clk); #1;
      exp_q = sb.pop_front();
      total++;
      if (qv !== exp_q) $display("FAIL reset[%0d]: q=%b expected=%b", i, qv, exp_q);
      else passed++;
    end
  endtask

  // Load 1010 and then 0101 on two consecutive edges.
  task automatic test_basic_load();
    logic [3:0] pats [2];
    pats[0] = 4'b1010;
    pats[1] = 4'b0101;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dv = pats[i];
      sb.push_back(pats[i]);
      @(posedge clk); #1;
      exp_q = sb.pop_front();
      total++;
      if (qv !== exp_q) $display("FAIL basic_load[%0d]: q=%b expected=%b", i, qv, exp_q);
      else passed++;
    end
  endtask

  // Toggle d between edges. q must keep the value captured at the last edge.
  task automatic test_mid_cycle();
    rst = 1'b1;
    dv  = 4'b1100;
    sb.push_back(4'b1100);
    @(posedge clk); #1;
    exp_q = sb.pop_front();
    total++;
    if (qv !== exp_q) $display("FAIL mid_load: q=%b expected=%b", qv, exp_q);
    else passed++;
    sb.push_back(4'b1100);
    #3 dv = 4'b0011;
    #1;
    total++;
    if (qv !== 4'b1100) $display("FAIL mid_toggle: q=%b expected=%b", qv, 4'b1100);
    else passed++;
    #2 dv = 4'b1100;
    #1;
    total++;
    if (qv !== 4'b1100) $display("FAIL mid_restore: q=%b expected=%b", qv, 4'b1100);
    else passed++;
    @(posedge clk); #1;
    exp_q = sb.pop_front();
    total++;
    if (qv !== exp_q) $display("FAIL mid_next_edge: q=%b expected=%b", qv, exp_q);
    else passed++;
  endtask

  // Assert reset and drive data on the same edge. The data must be discarded.
  // Then load 0110 after reset is released.
  task automatic test_reset_priority();
    rst = 1'b1;
    dv  = 4'b1111;
    sb.push_back(4'b1111);
    @(posedge clk); #1;
    exp_q = sb.pop_front();
    total++;
    if (qv !== exp_q) $display("FAIL prio_preload: q=%b expected=%b", qv, exp_q);
    else passed++;
    rst = 1'b0;
    sb.push_back(4'b0000);
    @(posedge clk); #1;
    exp_q = sb.pop_front();
    total++;
    if (qv !== exp_q) $display("FAIL prio_clear: q=%b expected=%b", qv, exp_q);
    else passed++;
    rst = 1'b1;
    dv  = 4'b0110;
    sb.push_back(4'b0110);
    @(posedge clk); #1;
    exp_q = sb.pop_front();
    total++;
    if (qv !== exp_q) $display("FAIL prio_release: q=%b expected=%b", qv, exp_q);
    else passed++;
  endtask

  // Pulse reset low strictly between two edges. The held 1001 must survive.
  task automatic test_async_immunity();
    rst = 1'b1;
    dv  = 4'b1001;
    sb.push_back(4'b1001);
    @(posedge clk); #1;
    exp_q = sb.pop_front();
    total++;
    if (qv !== exp_q) $display("FAIL async_preload: q=%b expected=%b", qv, exp_q);
    else passed++;
    sb.push_back(4'b1001);
    #2 rst = 1'b0;
    #2;
    total++;
    if (qv !== 4'b1001) $display("FAIL async_during_pulse: q=%b expected=%b", qv, 4'b1001);
    else passed++;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    exp_q = sb.pop_front();
    total++;
    if (qv !== exp_q) $display("FAIL async_after_pulse: q=%b expected=%b", qv, exp_q);
    else passed++;
  endtask

  // Random stream. The reference is the d value pushed before each edge,
  // which is a one-cycle-delayed copy of the input.
  task automatic test_random();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dv = 4'($urandom_range(0, 15));
      sb.push_back(dv);
      @(posedge clk); #1;
      exp_q = sb.pop_front();
      total++;
      if (qv !== exp_q) $display("FAIL random[%0d]: q=%b expected=%b", i, qv, exp_q);
      else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b0;
    dv     = 4'b1111;
    test_reset();
    test_basic_load();
    test_mid_cycle();
    test_reset_priority();
    test_async_immunity();
    test_random();
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: left=%0d expected=0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
